load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory and turns pipeline load/store requests into memory accesses.
- Handles byte, halfword and word sizes, little-endian byte lanes, and sign/zero extension of loads.
- Does read-modify-write for sub-word stores, because the memory only writes whole words.
- Detects misaligned and out-of-range accesses and reports them without touching memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the data memory; valid byte addresses are 0 .. 4*MEM_WORDS-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load result; 0 for stores and errors.
- rsp_err  out  2  bit0 = misaligned or illegal size; bit1 = out of range.
- mem_write_en  out  1  memory write strobe.
- mem_access_addr  out  32  word index, equal to byte address >> 2.
- mem_write_data  out  32  full word to write.
- mem_read_data  in  32  combinational read of the word at mem_access_addr.

Behaviour:
- Reset values: state IDLE; all captured registers 0; rsp_valid, rsp_rdata, rsp_err, mem_write_en, mem_access_addr, mem_write_data all 0; req_ready 1.
- Assertion of reset mid-operation aborts the access. mem_write_en drops immediately (asynchronously). No later write or response is issued.
- Accept: req_valid && req_ready at a rising edge. The unit captures write, size, unsigned, addr and wdata, then leaves IDLE. req_ready is decoded from the state.
- Error check, performed at accept:
  - misaligned = (size 01 && addr[0]) || (size 10 && addr[1:0] != 0) || size 11;
  - out of range = addr >= 4*MEM_WORDS;
  - if either is set, go to RESP with rsp_err set and no memory cycle. Both bits may be set together.
- States:
  - IDLE: waits for a request.
  - LOAD: drives mem_access_addr; extracts the lane from mem_read_data, extends it, and registers it.
  - RD: drives mem_access_addr; captures the old word (sub-word stores only).
  - WR: mem_write_en = 1 for exactly one cycle; mem_write_data = merged word for sub-word stores, req_wdata for word stores.
  - RESP: rsp_valid = 1 for one cycle, then back to IDLE.
- Transitions:
  - load: IDLE -> LOAD -> RESP -> IDLE;
  - word store: IDLE -> WR -> RESP -> IDLE;
  - sub-word store: IDLE -> RD -> WR -> RESP -> IDLE;
  - error: IDLE -> RESP -> IDLE.
- Latency from the accept edge to rsp_valid high: load 2 cycles, word store 2, sub-word store 3, error 1.
- Back-to-back requests: the earliest next accept is the cycle after RESP.
- Lanes, little-endian:
  - byte lane = addr[1:0];
  - half lane = addr[1] (low half when 0, high half when 1).
- Merge: the old word with only the addressed lane replaced by wdata[7:0] or wdata[15:0]; other bytes are preserved bit-exact.
- Extension: bit 7 or bit 15 of the selected lane is replicated into the upper bits when req_unsigned = 0; zeros are used when it is 1. Word loads pass through unchanged.
- mem_access_addr and mem_write_data hold their last values while in IDLE. mem_write_en is 0 in every state except WR.
- rsp_rdata and rsp_err are valid only while rsp_valid is high and are cleared to 0 on leaving RESP.
- The unit has no response backpressure; the consumer must take rsp_valid on the cycle it is asserted.

Test Plan:
- Memory word 5 = 0x8899AABB. Load byte at 0x15, signed -> 2 cycles after accept, rsp_rdata 0xFFFFFFAA, rsp_err 0. Same request unsigned -> 0x000000AA.
- Memory word 5 = 0x8899AABB. Store byte 0x11 at 0x16 -> exactly one mem_write_en pulse, at addr 5 with data 0x8811AABB; rsp_valid 3 cycles after accept. A following word load at 0x14 returns 0x8811AABB.
- Half load at 0x13 -> rsp_err 01 one cycle after accept, no write strobe, rsp_rdata 0. Word store at 0x1000 with MEM_WORDS = 1024 -> rsp_err 10, no write.
- Word store 0xDEADBEEF at 0x20 -> write at addr 8 one cycle after accept. Half load at 0x22, signed -> 0xFFFFDEAD.
- Reset asserted during the RD cycle of a byte store -> mem_write_en never rises, rsp_valid stays 0, req_ready returns to 1 and all outputs read 0.
- req_valid held high for 4 back-to-back word loads -> each is accepted 3 cycles apart, and req_ready is low for exactly the 2 cycles between accepts.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit between the pipeline and the word-addressed data memory
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req_*             pipeline request (valid/ready handshake, accepted only in IDLE)
//   rsp_*             one-cycle response pulse with extended load data and error bits
//   mem_*             word-addressed memory port; mem_read_data is a combinational read
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_write_en,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0]  SIZE_BYTE  = 2'b00;
  localparam logic [1:0]  SIZE_HALF  = 2'b01;
  localparam logic [1:0]  SIZE_WORD  = 2'b10;
  localparam logic [1:0]  SIZE_ILL   = 2'b11;
  // Compared at 33 bits so a full 4 GiB memory would not wrap the limit.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        sign_bit;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  assign accept       = req_valid && (state_q == IDLE);
  assign misaligned   = ((req_size == SIZE_HALF) && req_addr[0])
                     || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                     || (req_size == SIZE_ILL);
  assign out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
  assign req_err      = {out_of_range, misaligned};

  // Lane extraction and sign/zero extension of the word being read.
  always_comb begin
    lane_byte  = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_read_data[7:0];
      2'd1:    lane_byte = mem_read_data[15:8];
      2'd2:    lane_byte = mem_read_data[23:16];
      default: lane_byte = mem_read_data[31:24];
    endcase
    lane_half  = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    sign_bit   = 1'b0;
    load_value = mem_read_data;
    case (size_q)
      SIZE_BYTE: begin
        sign_bit   = ~unsigned_q & lane_byte[7];
        load_value = {{24{sign_bit}}, lane_byte};
      end
      SIZE_HALF: begin
        sign_bit   = ~unsigned_q & lane_half[15];
        load_value = {{16{sign_bit}}, lane_half};
      end
      default: load_value = mem_read_data;
    endcase
  end

  // Old word with only the addressed lane replaced by the store data.
  always_comb begin
    merged_word = mem_read_data;
    case (size_q)
      SIZE_BYTE: begin
        case (addr_q[1:0])
          2'd0:    merged_word[7:0]   = wdata_q[7:0];
          2'd1:    merged_word[15:8]  = wdata_q[7:0];
          2'd2:    merged_word[23:16] = wdata_q[7:0];
          default: merged_word[31:24] = wdata_q[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
        else           merged_word[15:0]  = wdata_q[15:0];
      end
      default: merged_word = wdata_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err != 2'b00)       state_d = RESP;
          else if (!req_write)        state_d = LOAD;
          else if (req_size == SIZE_WORD) state_d = WR;
          else                        state_d = RD;
        end
      end
      LOAD:    state_d = RESP;
      RD:      state_d = WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs decoded from state; mem_write_en falls with an async reset.
  always_comb begin
    req_ready    = (state_q == IDLE);
    mem_write_en = (state_q == WR);
    rsp_valid    = (state_q == RESP);
  end

  // Datapath registers. Error bits are captured at accept so an erroring
  // request reaches RESP with them already in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            err_q      <= req_err;
            // Word stores go straight to WR, so their data is loaded now.
            if (state_d == WR) mem_wdata_q <= req_wdata;
          end
        end
        LOAD: rdata_q     <= load_value;
        RD:   mem_wdata_q <= merged_word;
        RESP: begin
          rdata_q <= 32'h0;
          err_q   <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata       = rdata_q;
  assign rsp_err         = err_q;
  assign mem_access_addr = {2'b00, addr_q[31:2]};
  assign mem_write_data  = mem_wdata_q;

endmodule
